// File: rtl/cpu_pkg.sv
// Shared definitions for the Music_Rockcessor CPU: opcode encodings used by
// fetch and the controller, the fetch-stage state type and default widths.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_BR0  = 4'b0100;
    localparam logic [3:0] OP_BR1  = 4'b0101;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_DRAIN = 2'd1,
        FS_HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, word} pairs for the fetch stage.
// Registered output (no write-through); clear has priority over push/pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory, buffers
// responses in fetch_fifo and hands them to decode over valid/ready.
// Optional HALT detection is built when FETCH_HALT_DETECT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FS_RUN   | normal fetching; responses are queued
// FS_DRAIN | redirect hit an in-flight read; its response is thrown away
// FS_HALT  | HALT word queued; no new reads until redirect or reset
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [3:0]         OpCode,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic [ADDR_W-1:0] req_pc_d;
    logic              outstanding_q;
    logic              outstanding_d;

    logic              rsp_live;
    logic              push;
    logic              pop;
    logic              space;
    logic              halt_push;
    logic              issue_run;
    logic              issue_drain;
    logic              issue;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_rdata;

    // A response only counts when we are actually waiting for one.
    assign rsp_live = imem_rvalid & outstanding_q;
    assign pop      = instr_valid & instr_ready;
    assign push     = rsp_live & (state_q == FS_RUN) & ~redirect;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_push = push & is_halt(imem_rdata[INSTR_W-1 -: 4]);
    assign halted    = (state_q == FS_HALT);
`else
    assign halt_push = 1'b0;
    assign halted    = 1'b0;
`endif

    // Room for one more word after this cycle's push/pop. An outstanding read
    // always has a slot reserved, so a pop always frees enough space.
    always_comb begin
        if (pop) begin
            space = 1'b1;
        end else if (push) begin
            space = (fifo_count < CNT_W'(DEPTH - 1));
        end else begin
            space = ~fifo_full;
        end
    end

    // The HALT word's own push cycle must not launch a read past it.
    assign issue_run   = (state_q == FS_RUN) & (~outstanding_q | imem_rvalid) & space & ~halt_push;
    assign issue_drain = (state_q == FS_DRAIN) & rsp_live & space;
    assign issue       = rst_n & ~redirect & (issue_run | issue_drain);

    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc_q : '0;

    // Next-state: request bookkeeping, then FSM, then redirect override.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;

        if (rsp_live) begin
            outstanding_d = 1'b0;
        end
        if (issue) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end

        case (state_q)
            FS_RUN: begin
                if (halt_push) begin
                    state_d = FS_HALT;
                end
            end
            FS_DRAIN: begin
                if (rsp_live) begin
                    state_d = FS_RUN;
                end
            end
            default: state_d = state_q;
        endcase

        // A read still in flight must be swallowed before fetching resumes;
        // one arriving this very cycle is simply dropped.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (outstanding_q & ~imem_rvalid) begin
                state_d = FS_DRAIN;
            end else begin
                state_d = FS_RUN;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FS_RUN;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid = ~fifo_empty;
    assign instr_pc    = fifo_rdata[ENT_W-1 -: ADDR_W];
    assign instr       = fifo_rdata[INSTR_W-1:0];
    assign OpCode      = instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected requests and
// accepted instructions into queues; a monitor pops and compares them.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  OpCode;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halted;

    int          n_checks = 0;
    int          n_pass = 0;
    int          lat = 1;
    bit          halt_word_en = 1'b0;
    logic [15:0] exp_req_q[$];
    logic [31:0] exp_ins_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .OpCode      (OpCode),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_word_en && a == 16'd7) return {OP_HALT, 12'hABC};
        return {4'hA, a[11:0]};
    endfunction

    task automatic exp_req(input logic [15:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic exp_ins(input logic [15:0] pc);
        exp_ins_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic drive(input bit rdy, input bit rd, input logic [15:0] rpc);
        @(negedge clk);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rd ? rpc : 16'h0000;
        #1;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_req_left"}, exp_req_q.size(), 0);
        chk({tag, "_ins_left"}, exp_ins_q.size(), 0);
        exp_req_q.delete();
        exp_ins_q.delete();
    endtask

    // Instruction memory: one read in flight, response lat cycles after request.
    initial begin
        bit          pend;
        int          left;
        logic [15:0] paddr;
        pend = 1'b0;
        left = 0;
        paddr = 16'h0000;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = 16'hDEAD;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (left <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    left--;
                end
            end
            #1;
            if (rst_n && imem_req) begin
                pend  = 1'b1;
                left  = lat;
                paddr = imem_addr;
            end
        end
    end

    // Monitor: every request and every accepted instruction is checked in order.
    initial begin
        logic [15:0] ea;
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (imem_req) begin
                    chk("req_expected", {31'd0, exp_req_q.size() != 0}, 32'd1);
                    if (exp_req_q.size() != 0) begin
                        ea = exp_req_q.pop_front();
                        chk("imem_addr", imem_addr, ea);
                    end
                end
                if (instr_valid && instr_ready && !redirect) begin
                    chk("instr_expected", {31'd0, exp_ins_q.size() != 0}, 32'd1);
                    if (exp_ins_q.size() != 0) begin
                        ei = exp_ins_q.pop_front();
                        chk("instr_pc", instr_pc, ei[31:16]);
                        chk("instr", instr, ei[15:0]);
                        chk("opcode", OpCode, ei[15:12]);
                    end
                end
            end
        end
    end

    initial begin
        logic exp_h;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_halted", halted, 0);

        // Phase 1: streaming from reset, 5-cycle decode stall, then park.
        for (int a = 0; a <= 10; a++) exp_req(16'(a));
        for (int p = 0; p <= 8; p++) exp_ins(16'(p));
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1'b1;
            instr_ready = (c < 6) || (c >= 11 && c < 16);
            redirect = 1'b0;
            #1;
            if (c < 4) chk("startup_req", imem_req, 1);
            if (c >= 6 && c <= 10) chk("stall_no_req", imem_req, 0);
        end
        drained("p1");

        // Phase 2: 3-cycle memory, redirect to 0x40 while 0x0005 is in flight.
        lat = 3;
        exp_req(16'h0005);
        for (int a = 16'h40; a <= 16'h43; a++) exp_req(16'(a));
        exp_ins(16'h0040);
        exp_ins(16'h0041);
        for (int c = 0; c < 21; c++) begin
            drive((c >= 1 && c < 12), (c == 0 || c == 2), (c == 0) ? 16'h0005 : 16'h0040);
            if (c == 3) chk("drain_no_req", imem_req, 0);
            if (c == 4) chk("drain_cycle_req", imem_req, 1);
            if (c == 5) chk("discarded_not_queued", instr_valid, 0);
        end
        drained("p2");

        // Phase 3: redirect coincident with pop and imem_rvalid.
        lat = 1;
        exp_req(16'h0044);
        exp_req(16'h0045);
        exp_req(16'h0080);
        exp_req(16'h0081);
        exp_req(16'h0082);
        exp_ins(16'h0042);
        exp_ins(16'h0043);
        exp_ins(16'h0080);
        for (int c = 0; c < 10; c++) begin
            drive((c < 6), (c == 2), 16'h0080);
            if (c == 2) chk("redir_rsp_present", imem_rvalid, 1);
            if (c == 3) chk("flush_empty", instr_valid, 0);
        end
        drained("p3");

        // Phase 4: fetch address wraps from 0xFFFF to 0x0000.
        exp_req(16'hFFFE);
        exp_req(16'hFFFF);
        exp_req(16'h0000);
        exp_req(16'h0001);
        exp_ins(16'hFFFE);
        exp_ins(16'hFFFF);
        for (int c = 0; c < 9; c++) begin
            drive((c >= 1 && c < 5), (c == 0), 16'hFFFE);
        end
        drained("p4");

        // Phase 5: HALT word 0x0ABC at address 7, then redirect to 0x0010.
        halt_word_en = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
        for (int a = 5; a <= 7; a++) exp_req(16'(a));
        for (int p = 5; p <= 7; p++) exp_ins(16'(p));
`else
        for (int a = 5; a <= 13; a++) exp_req(16'(a));
        for (int p = 5; p <= 11; p++) exp_ins(16'(p));
`endif
        exp_req(16'h0010);
        exp_req(16'h0011);
        for (int c = 0; c < 16; c++) begin
            drive((c >= 1 && c < 10), (c == 0 || c == 10), (c == 0) ? 16'h0005 : 16'h0010);
`ifdef FETCH_HALT_DETECT_EN
            exp_h = (c >= 5 && c <= 10);
`else
            exp_h = 1'b0;
`endif
            if (c == 4 || c == 5 || c == 9 || c == 11) chk("halted", halted, exp_h);
            if (c == 11) chk("resume_req", imem_req, 1);
        end
        drained("p5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
